lsq_mem_responder: RTL and testbench



---
 rtl/lsq_pkg.sv | 35 +++
 rtl/lsq_req_fifo.sv | 56 +++++
 rtl/lsq_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_lsq_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the LSQ issue interface: request record, FSM states and
// the op/size encodings the LSQ also uses.
package lsq_pkg;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_STORE  = 1'b1;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic        store;
        logic        is_byte;
        logic [31:0] wdata;
        logic        from_lsq;
        logic [31:0] lw_data;
    } lsq_req_t;

    // Little-endian lane select with sign extension for byte loads.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic        is_byte);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        return (is_byte == SIZE_BYTE) ? {{24{b[7]}}, b} : word;
    endfunction

endpackage

// File: rtl/lsq_req_fifo.sv
// Synchronous request FIFO with wrapping pointers and an occupancy count.
// DEPTH must be a power of two and at least 2.
module lsq_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count, so a push at full is
    // dropped even when a pop happens on the same edge.
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/lsq_mem_responder.sv
// Memory-side responder for LSQ issue: buffers requests, runs fixed-latency
// array accesses in order and pulses a completion per request.
module lsq_mem_responder
    import lsq_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int MEM_LAT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic        req_store,
    input  logic        req_byte,
    input  logic [31:0] req_wdata,
    input  logic        req_from_lsq,
    input  logic [31:0] req_lw_data,
    output logic        cmp_valid,
    output logic [31:0] cmp_pc,
    output logic        cmp_is_load,
    output logic [31:0] cmp_data,
    output logic        busy
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int CTW   = $clog2(FIFO_DEPTH) + 1;
    localparam int REQ_W = $bits(lsq_req_t);
    localparam logic [CTW-1:0]   FULL_CNT = CTW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    lsq_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    lsq_req_t         r_work;
    lsq_req_t         w_req;
    lsq_req_t         w_head;
    logic [31:0]      r_rdata;
    logic [31:0]      r_mem [MEM_WORDS];
    logic [IDX_W-1:0] w_idx;
    logic [CTW-1:0]   w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_do_op;
    logic             w_cmp_fire;
    logic             r_cmp_valid;
    logic [31:0]      r_cmp_pc;
    logic             r_cmp_is_load;
    logic [31:0]      r_cmp_data;
    logic             w_unused;

    always_comb begin
        w_req          = '0;
        w_req.pc       = req_pc;
        w_req.addr     = req_addr;
        w_req.store    = req_store;
        w_req.is_byte  = req_byte;
        w_req.wdata    = req_wdata;
        w_req.from_lsq = req_from_lsq;
        w_req.lw_data  = req_lw_data;
    end

    lsq_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign req_ready = (w_count < FULL_CNT);
    assign busy      = !w_empty || (r_state != ST_IDLE);
    // MEM_WORDS is a power of two, so dropping high address bits is the wrap.
    assign w_idx     = r_work.addr[IDX_W+1:2];
    assign w_unused  = ^{r_work.addr[31:IDX_W+2], w_full};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_do_op     = 1'b0;
        w_cmp_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    // Forwarded stores still have to write the array.
                    if (w_head.from_lsq && (w_head.store == OP_LOAD)) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_cnt_nxt   = LAT_INIT;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_do_op     = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_cmp_fire  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_work        <= '0;
            r_rdata       <= '0;
            r_cmp_valid   <= 1'b0;
            r_cmp_pc      <= '0;
            r_cmp_is_load <= 1'b0;
            r_cmp_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop) r_work <= w_head;
            if (w_do_op && (r_work.store == OP_LOAD))
                r_rdata <= load_extract(r_mem[w_idx], r_work.addr[1:0], r_work.is_byte);
            r_cmp_valid <= w_cmp_fire;
            if (w_cmp_fire) begin
                r_cmp_pc      <= r_work.pc;
                r_cmp_is_load <= (r_work.store == OP_LOAD);
                if (r_work.store == OP_STORE)
                    r_cmp_data <= '0;
                else if (r_work.from_lsq)
                    r_cmp_data <= r_work.lw_data;
                else
                    r_cmp_data <= r_rdata;
            end
        end
    end

    // Array is never cleared; a reset on the final ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && w_do_op && (r_work.store == OP_STORE)) begin
            if (r_work.is_byte == SIZE_BYTE)
                r_mem[w_idx][{r_work.addr[1:0], 3'b000} +: 8] <= r_work.wdata[7:0];
            else
                r_mem[w_idx] <= r_work.wdata;
        end
    end

    assign cmp_valid   = r_cmp_valid;
    assign cmp_pc      = r_cmp_pc;
    assign cmp_is_load = r_cmp_is_load;
    assign cmp_data    = r_cmp_data;

endmodule

// File: tb/tb_lsq_mem_responder.sv
// Directed plus randomized bench for lsq_mem_responder against a queue/array
// reference model of completions and memory contents.
module tb_lsq_mem_responder;
    localparam int MEM_WORDS  = 1024;
    localparam int MEM_LAT    = 3;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_addr;
    logic        req_store;
    logic        req_byte;
    logic [31:0] req_wdata;
    logic        req_from_lsq;
    logic [31:0] req_lw_data;
    logic        cmp_valid;
    logic [31:0] cmp_pc;
    logic        cmp_is_load;
    logic [31:0] cmp_data;
    logic        busy;

    lsq_mem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .MEM_LAT    (MEM_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .req_addr     (req_addr),
        .req_store    (req_store),
        .req_byte     (req_byte),
        .req_wdata    (req_wdata),
        .req_from_lsq (req_from_lsq),
        .req_lw_data  (req_lw_data),
        .cmp_valid    (cmp_valid),
        .cmp_pc       (cmp_pc),
        .cmp_is_load  (cmp_is_load),
        .cmp_data     (cmp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: word-indexed memory plus expected completion stream.
    logic [31:0] mdl_mem [int];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_dat[$];
    logic        exp_ld[$];
    int          mon_cyc[$];
    logic [31:0] mon_dat[$];
    int          ncmp = 0;
    logic        prev_vld = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    task automatic model_apply(input logic [31:0] pc, input logic [31:0] addr, input logic st,
                               input logic by, input logic [31:0] wd, input logic fl,
                               input logic [31:0] lw);
        int          i;
        int          sh;
        logic [31:0] w;
        logic [31:0] r;
        logic [7:0]  b;
        i  = widx(addr);
        sh = 8 * int'(addr[1:0]);
        w  = mdl_mem.exists(i) ? mdl_mem[i] : 32'h0;
        if (st) begin
            if (by) w = (w & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
            else    w = wd;
            mdl_mem[i] = w;
            r = 32'h0;
        end else if (fl) begin
            r = lw;
        end else if (by) begin
            b = 8'(w >> sh);
            r = {{24{b[7]}}, b};
        end else begin
            r = w;
        end
        exp_pc.push_back(pc);
        exp_ld.push_back(!st);
        exp_dat.push_back(r);
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] addr, input logic st,
                        input logic by, input logic [31:0] wd, input logic fl,
                        input logic [31:0] lw, input bit track);
        int g = 0;
        req_valid = 1'b1; req_pc = pc; req_addr = addr; req_store = st; req_byte = by;
        req_wdata = wd; req_from_lsq = fl; req_lw_data = lw;
        while (!req_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) chk("ready_timeout", 32'(g), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (track) model_apply(pc, addr, st, by, wd, fl, lw);
    endtask

    task automatic wait_done();
        int g = 0;
        while ((exp_pc.size() != 0 || busy) && g < 500) begin
            @(posedge clk); #1; g++;
        end
        chk("drain", 32'(exp_pc.size()), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (cmp_valid) begin
                ncmp++;
                mon_cyc.push_back(cyc);
                mon_dat.push_back(cmp_data);
                chk("pulse_width", {31'h0, prev_vld}, 32'h0);
                if (exp_pc.size() == 0) begin
                    chk("unexpected_cmp_pc", cmp_pc, 32'hFFFF_FFFF);
                end else begin
                    chk("cmp_pc", cmp_pc, exp_pc.pop_front());
                    chk("cmp_is_load", {31'h0, cmp_is_load}, {31'h0, exp_ld.pop_front()});
                    chk("cmp_data", cmp_data, exp_dat.pop_front());
                end
            end
            prev_vld = cmp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; req_addr = '0; req_store = 1'b0;
        req_byte = 1'b0; req_wdata = '0; req_from_lsq = 1'b0; req_lw_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmp_valid", {31'h0, cmp_valid}, 32'h0);
        chk("rst_cmp_pc", cmp_pc, 32'h0);
        chk("rst_cmp_is_load", {31'h0, cmp_is_load}, 32'h0);
        chk("rst_cmp_data", cmp_data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Store then dependent load: completions 5 and 10 cycles after the store push.
        mon_cyc.delete(); mon_dat.delete();
        send(32'h4, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        t0 = cyc;
        send(32'h8, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("st_latency", 32'(mon_cyc[0] - t0), 32'd5);
        chk("ld_latency", 32'(mon_cyc[1] - t0), 32'd10);
        chk("ld_data_const", mon_dat[1], 32'hDEADBEEF);

        // Byte store into a zeroed word, then byte and word readback.
        mon_dat.delete();
        send(32'h10, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        send(32'h14, 32'h23, 1'b1, 1'b1, 32'h12345680, 1'b0, 32'h0, 1'b1);
        send(32'h18, 32'h23, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        send(32'h1C, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("ldb_sext", mon_dat[2], 32'hFFFFFF80);
        chk("ldw_lane3", mon_dat[3], 32'h80000000);

        // Forwarded load bypasses the array.
        mon_cyc.delete(); mon_dat.delete();
        send(32'hC, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1);
        t0 = cyc;
        send(32'h24, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("fwd_latency", 32'(mon_cyc[0] - t0), 32'd2);
        chk("fwd_data", mon_dat[0], 32'h1234);
        chk("fwd_no_array", mon_dat[1], 32'hDEADBEEF);

        // Six back-to-back: FIFO fills after the fifth accept.
        for (int i = 0; i < 6; i++) begin
            send(32'h100 + 32'(4 * i), 32'h80 + 32'(4 * (i % 3)), 1'((i % 2) == 0), 1'b0,
                 32'hA000 + 32'(i), 1'b0, 32'h0, 1'b1);
            if (i == 4) chk("ready_full", {31'h0, req_ready}, 32'h0);
        end
        wait_done();

        // Reset during ACCESS of a store drops it.
        send(32'h200, 32'h40, 1'b1, 1'b0, 32'h11112222, 1'b0, 32'h0, 1'b1);
        wait_done();
        n0 = ncmp;
        send(32'h204, 32'h40, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid_cmp_valid", {31'h0, cmp_valid}, 32'h0);
        repeat (8) begin @(posedge clk); #1; end
        chk("rstmid_no_cmp", 32'(ncmp - n0), 32'd0);
        mon_dat.delete();
        send(32'h208, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("rstmid_old_val", mon_dat[0], 32'h11112222);

        // Address wrap modulo memory depth.
        mon_dat.delete();
        send(32'h20C, 32'(MEM_WORDS * 4) + 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("wrap_load", mon_dat[0], 32'hDEADBEEF);

        // Random mix over a pre-initialised pool of words.
        for (int k = 0; k < 16; k++)
            send(32'h1000 + 32'(4 * k), 32'h400 + 32'(4 * k), 1'b1, 1'b0, $urandom, 1'b0, 32'h0, 1'b1);
        for (int n = 0; n < 80; n++) begin
            a = 32'h400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'(MEM_WORDS * 4 * $urandom_range(1, 3));
            send(32'h2000 + 32'(4 * n), a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
            end
        end
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
